// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential 8-digit packed-BCD to 32-bit binary converter.
// Reverse double-dabble: one right shift per clock (32 cycles per
// conversion) behind a start/busy/done handshake. Requests that contain
// a digit above 9 are rejected in one cycle with err set and binary
// cleared.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   request a conversion (sampled only when idle)
//   bcd     in   [31:0] packed BCD, digit 7 in [31:28] .. digit 0 in [3:0]
//   binary  out  [31:0] converted value, held until the next completion
//   busy    out  high while a conversion is running
//   done    out  one-cycle completion pulse (valid or rejected request)
//   err     out  last accepted request held an invalid digit
module bcd_to_bin (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bcd,
    output logic [31:0] binary,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state_q, state_d;
    logic [31:0] bcd_sr_q, bcd_sr_d;
    logic [31:0] bin_sr_q, bin_sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] binary_q, binary_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        bad_digit;
    logic [31:0] bcd_shift;
    logic [31:0] bcd_adj;
    logic [31:0] bin_shift;

    // Any nibble in A..F makes the whole request invalid.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bcd[i*4 +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // One step of reverse double-dabble: shift the 64-bit {bcd, bin}
    // pair right, then pull every BCD nibble that reached 8 or more back
    // down by 3 so it stays a valid halved decimal digit.
    always_comb begin
        bcd_shift = {1'b0, bcd_sr_q[31:1]};
        bin_shift = {bcd_sr_q[0], bin_sr_q[31:1]};
        bcd_adj   = bcd_shift;
        for (int i = 0; i < 8; i++) begin
            if (bcd_shift[i*4 +: 4] >= 4'd8)
                bcd_adj[i*4 +: 4] = bcd_shift[i*4 +: 4] - 4'd3;
        end
    end

    always_comb begin
        state_d  = state_q;
        bcd_sr_d = bcd_sr_q;
        bin_sr_d = bin_sr_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_digit) begin
                        binary_d = 32'd0;
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        bcd_sr_d = bcd;
                        bin_sr_d = 32'd0;
                        cnt_d    = 5'd0;
                        err_d    = 1'b0;
                        busy_d   = 1'b1;
                        state_d  = CONV;
                    end
                end
            end
            CONV: begin
                bcd_sr_d = bcd_adj;
                bin_sr_d = bin_shift;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    binary_d = bin_shift;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bcd_sr_q <= 32'd0;
            bin_sr_q <= 32'd0;
            cnt_q    <= 5'd0;
            binary_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_sr_q <= bcd_sr_d;
            bin_sr_q <= bin_sr_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign binary = binary_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bcd = 32'd0;
    logic [31:0] binary;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    bcd_to_bin dut (
        .clk(clk), .rst(rst), .start(start), .bcd(bcd),
        .binary(binary), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bcd;
        logic [31:0] exp_bin;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // advance one rising edge and sample just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from idle and check latency, busy length, results.
    task automatic run_conv(input logic [31:0] v, input logic [31:0] exp_bin,
                            input logic exp_err, input string tag);
        int lat;
        int busy_cnt;
        bit got;
        start = 1'b1;
        bcd   = v;
        step();                      // E0
        start = 1'b0;
        bcd   = 32'hFFFF_FFFF;       // must be ignored from here on
        lat = 0;
        busy_cnt = 0;
        got = done;
        if (busy) busy_cnt++;
        for (int n = 1; n <= 40 && !got; n++) begin
            step();
            lat = n;
            if (busy) busy_cnt++;
            got = done;
        end
        chk({tag, " latency"}, lat, exp_err ? 0 : 32);
        chk({tag, " busy_cycles"}, busy_cnt, exp_err ? 0 : 32);
        chk({tag, " binary"}, binary, exp_bin);
        chk({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
        step();
        chk({tag, " done_pulse_end"}, {31'd0, done}, 32'd0);
    endtask

    function automatic logic [31:0] bcd_value(input logic [31:0] v);
        logic [31:0] acc = 0;
        for (int i = 7; i >= 0; i--) acc = acc * 10 + 32'(v[i*4 +: 4]);
        return acc;
    endfunction

    vec_t vecs[10];

    initial begin
        int dcnt;
        int t;
        int done_at[$];
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1] = '{32'h9999_9999, 32'h05F5_E0FF, 1'b0};
        vecs[2] = '{32'h0001_2345, 32'h0000_3039, 1'b0};
        vecs[3] = '{32'h0000_0010, 32'h0000_000A, 1'b0};
        vecs[4] = '{32'h0000_A001, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_0007, 32'h0000_0007, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h00BC_614E, 1'b0};
        vecs[7] = '{32'h9999_999A, 32'h0000_0000, 1'b1};
        vecs[8] = '{32'h5000_0000, 32'h02FA_F080, 1'b0};
        vecs[9] = '{32'hF000_0000, 32'h0000_0000, 1'b1};

        #12;
        chk("reset binary", binary, 32'd0);
        chk("reset flags", {29'd0, busy, done, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) run_conv(vecs[i].bcd, vecs[i].exp_bin, vecs[i].exp_err, $sformatf("vec%0d", i));

        // err set, then cleared on the accepting edge of a valid request
        run_conv(32'h0000_0B00, 32'd0, 1'b1, "inv2");
        start = 1'b1; bcd = 32'h0000_0007;
        step();
        start = 1'b0;
        chk("err cleared at accept", {31'd0, err}, 32'd0);
        chk("binary held at accept", binary, 32'd0);
        for (int n = 0; n < 40 && !done; n++) step();
        chk("post-err binary", binary, 32'd7);
        step();

        // start pulsed at E5 and at E32 during a conversion: ignored
        start = 1'b1; bcd = 32'h0000_0042;
        step();                              // E0
        start = 1'b0;
        for (int n = 1; n <= 4; n++) step(); // E4
        start = 1'b1; bcd = 32'h0000_0099;
        step();                              // E5
        start = 1'b0;
        for (int n = 6; n <= 31; n++) step(); // E31
        start = 1'b1;
        step();                              // E32
        start = 1'b0;
        chk("pulse done at E32", {31'd0, done}, 32'd1);
        chk("pulse binary", binary, 32'h2A);
        dcnt = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (done || busy) dcnt++;
        end
        chk("pulse no requeue", dcnt, 0);

        // start held high: accepts at E0, E33, E66
        start = 1'b1; bcd = 32'h0000_0042;
        step();                              // E0
        t = 0;
        while (done_at.size() < 3 && t < 120) begin
            step();
            t++;
            if (done) done_at.push_back(t);
        end
        start = 1'b0;
        chk("held count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            chk("held done1", done_at[0], 32);
            chk("held done2", done_at[1], 65);
            chk("held done3", done_at[2], 98);
        end
        for (int n = 0; n < 40 && busy; n++) step();
        step();

        // async reset mid-conversion
        start = 1'b1; bcd = 32'h0000_0123;
        step();
        start = 1'b0;
        for (int n = 1; n <= 10; n++) step();
        rst = 1'b1;
        #1;
        chk("midrst binary", binary, 32'd0);
        chk("midrst flags", {29'd0, busy, done, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (done) dcnt++;
        end
        chk("midrst no done", dcnt, 0);
        run_conv(32'h0000_0123, 32'd123, 1'b0, "after_rst");

        // random valid BCD against a decimal reference
        for (int k = 0; k < 1000; k++) begin
            logic [31:0] v;
            for (int d = 0; d < 8; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
            start = 1'b1; bcd = v;
            step();
            start = 1'b0;
            for (int n = 0; n < 40 && !done; n++) step();
            chk($sformatf("rand %h binary", v), binary, bcd_value(v));
            chk($sformatf("rand %h err", v), {31'd0, err}, 32'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential 8-digit packed-BCD to binary converter, the inverse of the team's combinational binary-to-BCD block. It sits between the game's decimal-entry/score logic and the binary arithmetic datapath, e.g. for converting a BCD score or setting back to binary. It implements reverse double-dabble iteratively, one shift per clock, behind a start/busy/done handshake. It flags invalid BCD digits instead of producing garbage.

## Interface
- No parameters; fixed at 8 digits / 32-bit BCD in, 32-bit binary out.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request conversion; sampled only when idle
- bcd  input  32  packed BCD, digit 7 in [31:28] … digit 0 in [3:0]; sampled on the accepting edge only
- binary  output  32  converted value, zero-extended (max 99,999,999 = 0x05F5E0FF); held until next completion
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle completion pulse
- err  output  1  last accepted request contained a digit > 9

## Operation
- Reset (async, rst=1): state IDLE, binary=0, busy=0, done=0, err=0, shift count=0, internal shift registers=0. Takes effect immediately, including mid-conversion; the aborted conversion never produces done.
- States: IDLE, CONV.
- IDLE, start=0: hold; done forced to 0.
- IDLE, start=1 (accepting edge):
  - All eight digits ≤ 9: load bcd_sr<=bcd, bin_sr<=0, cnt<=0, err<=0, busy<=1, state<=CONV.
  - Any digit ≥ 0xA: binary<=0, err<=1, done<=1, busy stays 0, state stays IDLE. No conversion.
- CONV, each edge: concatenate {bcd_sr, bin_sr} (64 bits) and shift right 1; bit 0 of bcd_sr enters bin_sr[31]. Then, on the shifted bcd_sr, each nibble ≥ 8 has 3 subtracted (all 8 nibbles in parallel, 4-bit arithmetic). cnt<=cnt+1.
- CONV, edge with cnt==31 (32nd shift): binary<=final shifted bin_sr, done<=1, busy<=0, state<=IDLE. bcd_sr is all zero at this point for valid input.
- start during CONV is ignored, not queued; bcd changes during CONV have no effect.
- err stays set until the next accepted start, which clears it. binary is not cleared by an accepted start; it changes only at completion or on an error (to 0).
- done is high for exactly one cycle per accepted request, valid or invalid.

## Timing
- Accepting edge E0. Valid request: busy high after E0 through E32; shifts on E1..E32; binary and done update on E32; done high for cycle E32–E33. Latency 32 cycles.
- Invalid request: err, done, binary=0 update on E0; done high for cycle E0–E1. Latency 1 cycle.
- At E32 the state is still CONV, so start at E32 is ignored. The earliest next accept is E33, giving back-to-back throughput of 33 cycles per conversion.
- All outputs are registered; no combinational path from start or bcd to any output.

## Test plan
- After reset, start with bcd=0x00000000: done at E32, binary=0, err=0; busy high exactly 32 cycles.
- bcd=0x99999999: binary=0x05F5E0FF at done; bcd=0x00012345: binary=0x00003039; bcd=0x00000010: binary=0x0000000A.
- bcd=0x0000A001: done and err=1 one cycle after accept, binary=0, busy never high. A following valid start with 0x00000007 clears err at accept and gives binary=7.
- Start pulsed at E5 and E32 during a conversion of 0x00000042: single done, binary=0x2A. Start held high continuously: conversions accepted at E0, E33, E66.
- Assert rst at E10 mid-conversion: all outputs 0 immediately, no done afterwards. A new start after release converts correctly.
- Random valid BCD (≥1000 vectors) against a reference model: binary equals the decimal value on every done, err=0.
